// File: rtl/icache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl_pkg
// Description : Shared sizing, address-field ranges and FSM encoding for the
//               instruction-cache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_refill_ctrl_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int BLOCK_SIZE = 16;
    localparam int CACHE_SIZE = 1024;
    localparam int TAG_SIZE   = 18;
    localparam int CNT_W      = 32;

    localparam int OFF_W   = $clog2(BLOCK_SIZE);
    localparam int IDX_W   = $clog2(CACHE_SIZE);
    localparam int RAM_AW  = IDX_W + OFF_W;
    localparam int OFF_LSB = 0;
    localparam int OFF_MSB = OFF_LSB + OFF_W - 1;
    localparam int IDX_LSB = OFF_MSB + 1;
    localparam int IDX_MSB = IDX_LSB + IDX_W - 1;
    localparam int TAG_LSB = IDX_MSB + 1;
    localparam int TAG_MSB = TAG_LSB + TAG_SIZE - 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOOKUP = 2'd1;
    localparam logic [1:0] c_ST_REFILL = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl_if
// Description : CPU fetch port, memory refill port and perf counters bundled
//               as one interface; slave is the controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_refill_ctrl_if;
    import icache_refill_ctrl_pkg::*;

    logic                 fetch_req;
    logic [WORD_SIZE-1:0] fetch_addr;
    logic                 fetch_ready;
    logic                 fetch_valid;
    logic [WORD_SIZE-1:0] fetch_data;
    logic                 flush;
    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic [CNT_W-1:0]     hit_count;
    logic [CNT_W-1:0]     miss_count;

    modport slave (
        input  fetch_req, fetch_addr, flush, mem_ack, mem_rdata,
        output fetch_ready, fetch_valid, fetch_data, mem_req, mem_addr,
               hit_count, miss_count
    );

    modport master (
        output fetch_req, fetch_addr, flush, mem_ack, mem_rdata,
        input  fetch_ready, fetch_valid, fetch_data, mem_req, mem_addr,
               hit_count, miss_count
    );

endinterface
`default_nettype wire

// File: rtl/icache_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : icache_data_ram
// Description : Line data store, one synchronous word read port and one word
//               write port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_data_ram #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  wire logic          clk,
    input  wire logic          i_rd_en,
    input  wire logic [AW-1:0] i_rd_addr,
    output logic      [DW-1:0] o_rd_data,
    input  wire logic          i_wr_en,
    input  wire logic [AW-1:0] i_wr_addr,
    input  wire logic [DW-1:0] i_wr_data
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : I-cache miss controller: tag/valid arrays, one-cycle hits,
//               word-by-word line refill over a req/ack bus, whole-cache flush.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst,
    icache_refill_ctrl_if.slave  bus
);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [WORD_SIZE-1:0] r_req_addr;
    logic [OFF_W-1:0]     r_cnt;
    logic [WORD_SIZE-1:0] r_resp_word;
    logic                 r_flush_pend;
    logic [CACHE_SIZE-1:0] r_valid;
    logic [TAG_SIZE-1:0]  r_tag [CACHE_SIZE];
    logic [CNT_W-1:0]     r_hit_count;
    logic [CNT_W-1:0]     r_miss_count;

    logic [TAG_SIZE-1:0]  w_req_tag;
    logic [IDX_W-1:0]     w_req_idx;
    logic [OFF_W-1:0]     w_req_off;
    logic                 w_hit;
    logic                 w_ready_st;
    logic                 w_fetch_ready;
    logic                 w_fetch_valid;
    logic                 w_sel_resp;
    logic                 w_accept;
    logic                 w_refill_ack;
    logic                 w_final_ack;
    logic                 w_lookup_miss;
    logic [WORD_SIZE-1:0] w_ram_rdata;

    assign w_req_tag     = r_req_addr[TAG_MSB:TAG_LSB];
    assign w_req_idx     = r_req_addr[IDX_MSB:IDX_LSB];
    assign w_req_off     = r_req_addr[OFF_MSB:OFF_LSB];
    assign w_hit         = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_lookup_miss = (r_state == c_ST_LOOKUP) && !w_hit;
    assign w_refill_ack  = (r_state == c_ST_REFILL) && bus.mem_ack;
    assign w_final_ack   = w_refill_ack && (r_cnt == OFF_W'(BLOCK_SIZE - 1));
    assign w_fetch_ready = w_ready_st && !r_flush_pend && !rst;
    assign w_accept      = bus.fetch_req && w_fetch_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_next_state = c_ST_LOOKUP;
            c_ST_LOOKUP: begin
                if (!w_hit)        w_next_state = c_ST_REFILL;
                else if (w_accept) w_next_state = c_ST_LOOKUP;
                else               w_next_state = c_ST_IDLE;
            end
            c_ST_REFILL: if (w_final_ack) w_next_state = c_ST_DONE;
            c_ST_DONE:   w_next_state = w_accept ? c_ST_LOOKUP : c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready_st    = 1'b0;
        w_fetch_valid = 1'b0;
        w_sel_resp    = 1'b0;
        bus.mem_req   = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_ready_st = 1'b1;
            c_ST_LOOKUP: begin
                w_ready_st    = w_hit;
                w_fetch_valid = w_hit;
            end
            c_ST_REFILL: bus.mem_req = 1'b1;
            c_ST_DONE: begin
                w_ready_st    = 1'b1;
                w_fetch_valid = 1'b1;
                w_sel_resp    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.fetch_ready = w_fetch_ready;
    assign bus.fetch_valid = w_fetch_valid;
    assign bus.fetch_data  = !w_fetch_valid ? '0 : (w_sel_resp ? r_resp_word : w_ram_rdata);
    assign bus.mem_addr    = {w_req_tag, w_req_idx, r_cnt};
    assign bus.hit_count   = r_hit_count;
    assign bus.miss_count  = r_miss_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_addr   <= '0;
            r_cnt        <= '0;
            r_resp_word  <= '0;
            r_flush_pend <= 1'b0;
            r_valid      <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_accept) begin
                r_req_addr <= bus.fetch_addr;
            end
            // A flush pulse landing on the apply cycle must survive for the next IDLE.
            if (bus.flush) begin
                r_flush_pend <= 1'b1;
            end else if (r_state == c_ST_IDLE) begin
                r_flush_pend <= 1'b0;
            end
            if ((r_state == c_ST_IDLE) && r_flush_pend) begin
                r_valid <= '0;
            end else if (w_lookup_miss) begin
                r_valid[w_req_idx] <= 1'b0;
            end else if (w_final_ack) begin
                r_valid[w_req_idx] <= 1'b1;
            end
            if (w_lookup_miss) begin
                r_cnt        <= '0;
                r_miss_count <= r_miss_count + 1'b1;
            end else if (w_refill_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == c_ST_LOOKUP) && w_hit) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_refill_ack && (r_cnt == w_req_off)) begin
                r_resp_word <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_final_ack) begin
            r_tag[w_req_idx] <= w_req_tag;
        end
    end

    icache_data_ram #(
        .AW (RAM_AW),
        .DW (WORD_SIZE)
    ) u_data_ram (
        .clk       (clk),
        .i_rd_en   (w_accept),
        .i_rd_addr (bus.fetch_addr[IDX_MSB:OFF_LSB]),
        .o_rd_data (w_ram_rdata),
        .i_wr_en   (w_refill_ack),
        .i_wr_addr ({w_req_idx, r_cnt}),
        .i_wr_data (bus.mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_ctrl
// Description : Directed self-checking bench for icache_refill_ctrl with a
//               req/ack memory responder returning addr ^ 0xA5A50000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    localparam logic [31:0] c_KEY = 32'hA5A5_0000;

    logic clk;
    logic rst;
    icache_refill_ctrl_if bus ();

    icache_refill_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp;
    int n_err;
    logic [27:0] exp_line;
    logic        stall_en;
    int word_idx;
    int wait_cnt;
    int acks_total;
    int mem_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks on the following posedge, optional 0-3 cycle stall per word.
    initial begin
        word_idx   = 0;
        wait_cnt   = 0;
        acks_total = 0;
        mem_bad    = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.mem_ack = 1'b0;
                word_idx    = 0;
                wait_cnt    = 0;
            end else if (bus.mem_req) begin
                if (bus.mem_addr !== {exp_line, word_idx[3:0]}) mem_bad++;
                if (wait_cnt == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ c_KEY;
                    acks_total++;
                    word_idx = (word_idx == BLOCK_SIZE - 1) ? 0 : word_idx + 1;
                    wait_cnt = stall_en ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt--;
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
    end

    task automatic fetch_one(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input int exp_lat);
        int n;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        n = 0;
        while (!bus.fetch_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {31'd0, bus.fetch_ready}, 32'd1);
        tick();
        bus.fetch_req = 1'b0;
        n = 0;
        while (!bus.fetch_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, bus.fetch_valid}, 32'd1);
        check({tag, "_data"}, bus.fetch_data, exp_data);
        if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
        tick();
        check({tag, "_pulse"}, {31'd0, bus.fetch_valid}, 32'd0);
    endtask

    task automatic wait_word(input int idx);
        int n;
        n = 0;
        while (word_idx != idx && n < 200) begin
            tick();
            n++;
        end
        check("wait_word", word_idx, idx);
    endtask

    initial begin
        int a0;
        n_cmp = 0;
        n_err = 0;
        stall_en = 1'b0;
        exp_line = '0;
        rst = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.flush      = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus.fetch_ready}, 32'd0);
        check("rst_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check("rst_memreq", {31'd0, bus.mem_req}, 32'd0);
        check("rst_data", bus.fetch_data, 32'd0);
        check("rst_hits", bus.hit_count, 32'd0);
        check("rst_miss", bus.miss_count, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("idle_ready", {31'd0, bus.fetch_ready}, 32'd1);

        // Cold miss: accept, lookup, 16 single-cycle acks, then DONE.
        exp_line = 28'h0000002;
        a0 = acks_total;
        fetch_one("cold", 32'h0000_0025, 32'hA5A5_0025, 17);
        check("cold_acks", acks_total - a0, 16);
        check("cold_miss", bus.miss_count, 32'd1);
        check("cold_hits", bus.hit_count, 32'd0);
        check("cold_seq", mem_bad, 0);

        // Back-to-back hit stream over the installed line.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h20;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("hs_valid", {31'd0, bus.fetch_valid}, 32'd1);
            check("hs_data", bus.fetch_data, 32'hA5A5_0020 + i);
            check("hs_memreq", {31'd0, bus.mem_req}, 32'd0);
            if (i < 15) bus.fetch_addr = 32'h21 + i;
            else bus.fetch_req = 1'b0;
            tick();
        end
        check("hs_hits", bus.hit_count, 32'd16);
        check("hs_miss", bus.miss_count, 32'd1);

        // Conflict on index 2: tag 1 evicts tag 0, then tag 0 misses again.
        exp_line = 28'h0000402;
        fetch_one("conf1", 32'h0000_4025, 32'hA5A5_4025, 17);
        exp_line = 28'h0000002;
        fetch_one("conf2", 32'h0000_0025, 32'hA5A5_0025, 17);
        check("conf_miss", bus.miss_count, 32'd3);
        check("conf_seq", mem_bad, 0);

        // Flush pulsed mid-refill of line 0x100.
        exp_line = 28'h0000100;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0000_1000;
        tick();
        bus.fetch_req = 1'b0;
        wait_word(5);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        a0 = 0;
        while (!bus.fetch_valid && a0 < 200) begin
            tick();
            a0++;
        end
        check("fl_valid", {31'd0, bus.fetch_valid}, 32'd1);
        check("fl_data", bus.fetch_data, 32'hA5A5_1000);
        check("fl_ready_done", {31'd0, bus.fetch_ready}, 32'd0);
        tick();
        check("fl_ready_idle", {31'd0, bus.fetch_ready}, 32'd0);
        tick();
        check("fl_ready_after", {31'd0, bus.fetch_ready}, 32'd1);
        check("fl_miss", bus.miss_count, 32'd4);

        // Previously resident 0x25 now misses; served with random ack stalls.
        stall_en = 1'b1;
        exp_line = 28'h0000002;
        fetch_one("stall", 32'h0000_0025, 32'hA5A5_0025, -1);
        check("stall_miss", bus.miss_count, 32'd5);
        exp_line = 28'h0000100;
        fetch_one("fl_line", 32'h0000_1003, 32'hA5A5_1003, -1);
        check("fl_line_miss", bus.miss_count, 32'd6);
        check("stall_hits", bus.hit_count, 32'd16);
        check("stall_seq", mem_bad, 0);
        stall_en = 1'b0;
        tick();
        tick();

        // Reset at word 7 abandons the refill.
        exp_line = 28'h0000402;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0000_4025;
        tick();
        bus.fetch_req = 1'b0;
        wait_word(7);
        check("rr_memreq_pre", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rr_memreq", {31'd0, bus.mem_req}, 32'd0);
        check("rr_hits", bus.hit_count, 32'd0);
        check("rr_miss", bus.miss_count, 32'd0);
        check("rr_ready", {31'd0, bus.fetch_ready}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_line = 28'h0000002;
        a0 = acks_total;
        fetch_one("rr_refill", 32'h0000_0025, 32'hA5A5_0025, 17);
        check("rr_acks", acks_total - a0, 16);
        check("rr_miss2", bus.miss_count, 32'd1);
        check("rr_seq", mem_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
